relu_stream_ctrl: RTL
=====================

// Module: relu_stream_ctrl
// PURPOSE
//  Sequencer for the NPU ReLU stage. On a start command it streams cfg_len words
//  from the activation buffer through the registered ReLU unit and writes the
//  results to the destination buffer. It also reports how many words were clamped.
//  It sits between the layer controller and the buffer SRAM read/write ports.
// PARAMETERS
//  DATA_W  16  word width; bit DATA_W-1 is the sign bit
//  ADDR_W  10  buffer address width; addresses wrap modulo 2^ADDR_W
//  LEN_W   11  width of cfg_len and neg_count
// PORTS
//  CLKEXT        in   1       clock; all logic is on the rising edge
//  reset         in   1       synchronous, active-high reset
//  start         in   1       command strobe; accepted only in IDLE
//  cfg_src_base  in   ADDR_W  first source address
//  cfg_dst_base  in   ADDR_W  first destination address
//  cfg_len       in   LEN_W   number of words; 0 is legal
//  cfg_bypass    in   1       pass data unmodified (drives relu_bypass)
//  busy          out  1       high in ISSUE and DRAIN
//  done          out  1       one-cycle pulse in DONE
//  neg_count     out  LEN_W   words clamped in the last/current command
//  rd_en         out  1       source read strobe
//  rd_addr       out  ADDR_W  source address
//  rd_data       in   DATA_W  read data, valid the cycle after rd_en
//  relu_data_in  out  DATA_W  to ReLU data input = rd_data (combinational)
//  relu_en       out  1       ReLU enable = registered rd_en
//  relu_bypass   out  1       latched cfg_bypass
//  relu_reset    out  1       ReLU output clear
//  relu_out      in   DATA_W  ReLU registered output
//  wr_en         out  1       destination write strobe
//  wr_addr       out  ADDR_W  destination address
//  wr_data       out  DATA_W  = relu_out (combinational)
// BEHAVIOUR
//  Reset values: FSM=IDLE; busy, done, rd_en, relu_en, wr_en, relu_bypass = 0;
//   addresses = 0; neg_count = 0; relu_reset = 1 while reset is high.
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//  IDLE:
//   - start=1 latches cfg_* and clears neg_count.
//   - relu_reset pulses high for that cycle.
//   - next state = ISSUE, or DONE if cfg_len=0.
//  ISSUE:
//   - issue k = 0..len-1: rd_en=1, rd_addr = src+k (wraps).
//   - after the last issue, go to DRAIN.
//  Pipeline per word k:
//   - read at cycle t;
//   - relu_en=1 at t+1 (ReLU captures rd_data);
//   - wr_en=1 at t+2 with wr_addr = dst+k (wraps) and wr_data = relu_out.
//  DRAIN: wait until the last wr_en has been asserted, then go to DONE.
//  DONE: done=1 and busy=0 for one cycle, then IDLE.
//  Latency: start accepted at cycle 0 -> reads in cycles 1..N, writes in cycles
//   3..N+2, done in cycle N+3. With N=0, done is in cycle 1 and no rd/wr occurs.
//  neg_count: +1 per relu_en cycle where rd_data[DATA_W-1]=1 and bypass=0.
//   It holds its value after DONE until the next accepted start.
//  start while busy or in DONE is ignored; cfg_* changes after acceptance are ignored.
//  relu_reset and relu_en are never high in the same cycle (the ReLU gives EN priority).
//  Reset mid-operation: the next cycle is IDLE with all strobes 0. In-flight reads
//   and writes are dropped and no done pulse is produced.
//  Address wrap: with src=1023 and N=2, reads go to 1023 then 0.
// TESTING
//  - src=0,dst=512,N=4, data {5,-3,0x7FFF,0x8000}, bypass=0
//    -> writes {5,0,0x7FFF,0} at 512..515, neg_count=2, done in cycle 7.
//  - same data with bypass=1 -> writes echo the input unchanged, neg_count=0.
//  - N=0 -> no rd_en/wr_en, done in cycle 1, busy never high.
//  - src=1022,dst=1023,N=3 -> reads 1022,1023,0; writes 1023,0,1.
//  - start pulsed in cycles 2 and 4 of an N=4 run -> ignored; exactly one done pulse.
//  - reset in cycle 3 of an N=8 run -> next cycle all strobes 0 and IDLE; no done;
//    a new start then completes normally.

Source files
------------

// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl: sequencer for the NPU ReLU stage. It streams cfg_len words
// from the activation buffer through the external registered ReLU unit into the
// destination buffer, and counts how many words the ReLU clamped to zero.
module relu_stream_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              CLKEXT,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_bypass,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  neg_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] relu_data_in,
  output logic              relu_en,
  output logic              relu_bypass,
  output logic              relu_reset,
  input  logic [DATA_W-1:0] relu_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [LEN_W-1:0]  remaining_q, neg_count_q;
  logic              bypass_q, relu_en_q, wr_en_q;
  logic              accept;

  // A command is taken only while idle; later starts and cfg changes are ignored
  assign accept = (state == IDLE) && start;

  // State register
  always_ff @(posedge CLKEXT) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and strobe decode; DRAIN ends once the final write is on the bus
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (cfg_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (remaining_q == LEN_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_en_q && !relu_en_q) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch and read-side address/length counters
  always_ff @(posedge CLKEXT) begin
    if (reset) begin
      rd_addr_q   <= '0;
      remaining_q <= '0;
      bypass_q    <= 1'b0;
    end else if (accept) begin
      rd_addr_q   <= cfg_src_base;
      remaining_q <= cfg_len;
      bypass_q    <= cfg_bypass;
    end else if (state == ISSUE) begin
      rd_addr_q   <= rd_addr_q + ADDR_W'(1);
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

  // Strobe pipeline: read data returns one cycle later, ReLU output one more
  always_ff @(posedge CLKEXT) begin
    if (reset) begin
      relu_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      relu_en_q <= rd_en;
      wr_en_q   <= relu_en_q;
    end
  end

  // Destination address advances after each write, wrapping naturally
  always_ff @(posedge CLKEXT) begin
    if (reset)        wr_addr_q <= '0;
    else if (accept)  wr_addr_q <= cfg_dst_base;
    else if (wr_en_q) wr_addr_q <= wr_addr_q + ADDR_W'(1);
  end

  // Clamp counter: a negative word entering the ReLU without bypass gets zeroed
  always_ff @(posedge CLKEXT) begin
    if (reset)       neg_count_q <= '0;
    else if (accept) neg_count_q <= '0;
    else if (relu_en_q && rd_data[DATA_W-1] && !bypass_q)
      neg_count_q <= neg_count_q + LEN_W'(1);
  end

  // relu_en is masked during reset so it can never coincide with relu_reset
  assign relu_en      = relu_en_q & ~reset;
  assign relu_reset   = reset | accept;
  assign relu_bypass  = bypass_q;
  assign relu_data_in = rd_data;
  assign rd_addr      = rd_addr_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = relu_out;
  assign neg_count    = neg_count_q;

endmodule
